ddr_refresh_sequencer: RTL and testbench
========================================

# ddr_refresh_sequencer

Executes DDR3 refresh cycles on behalf of the refresh request counter. It watches the counter's `want`/`need` outputs and borrows the DDR command bus from the main command sequencer through a four-phase ownership handshake. It then issues PRECHARGE ALL followed by one or more REFRESH commands with programmable tRP/tRFC spacing, and answers each REFRESH with a one-cycle `grant` pulse back to the counter.

## Interface
Parameters:
- none (all timing is run-time programmable through ports)

Ports:
- `clk`  in  1  system clock; all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `en`  in  1  1 = refreshes allowed; 0 = no new ownership requests (a sequence in progress completes)
- `t_rp`  in  4  PRE-to-REF spacing in clk; 0 treated as 1
- `t_rfc`  in  9  REF-to-next-command spacing in clk; 0 treated as 1
- `want`  in  1  from refresh counter: at least one refresh pending
- `need`  in  1  from refresh counter: refresh urgent (≥8 pending)
- `seq_idle`  in  1  main sequencer has no queued transactions
- `own_rq`  out  1  request for command-bus ownership
- `own_ack`  in  1  main sequencer has stopped and yielded the bus; held until `own_rq` falls
- `grant`  out  1  to refresh counter: 1-cycle pulse per issued REFRESH
- `cmd_valid`  out  1  command strobe, 1 cycle
- `cmd_ras_n`, `cmd_cas_n`, `cmd_we_n`  out  1 each  DDR3 command encoding
- `cmd_a10`  out  1  A10 (1 = all banks for PRE)
- `busy`  out  1  state ≠ IDLE

## Operation
- All outputs are registered. Reset and idle values: `own_rq=0`, `grant=0`, `cmd_valid=0`, `cmd_ras_n=cmd_cas_n=cmd_we_n=1`, `cmd_a10=0`, `busy=0`.
- Trigger condition: `T = en && (need || (want && seq_idle))`.
- States:
  - IDLE: go to REQ when T=1 and `own_ack=0`.
  - REQ: `own_rq=1`. On `own_ack=1`, go to PRE. `want`/`need` are ignored while waiting; the request is never withdrawn.
  - PRE: issue PRECHARGE ALL (ras_n=0, cas_n=1, we_n=0, a10=1, valid=1) for 1 cycle. Load the wait counter with max(t_rp,1)−1. Go to WAIT_RP.
  - WAIT_RP: decrement; at 0 go to REF.
  - REF: issue REFRESH (ras_n=0, cas_n=0, we_n=1, a10=0, valid=1) and `grant=1` in the same cycle. Load the counter with max(t_rfc,1)−1. Increment `burst_cnt`. Go to WAIT_RFC.
  - WAIT_RFC: decrement; at 0 either continue the burst (see Configuration) or go to RELEASE.
  - RELEASE: `own_rq=0`. Go to IDLE once `own_ack=0`.
- `t_rp`/`t_rfc` are sampled only when the counter is loaded. Changing them mid-wait has no effect on the current wait.
- `burst_cnt` is 4 bits and is cleared in PRE. It caps a burst at 8 REFs and never wraps.
- Reset asserted mid-sequence: all state clears immediately and `own_rq` drops. The main sequencer must treat this as a release.
- `en` falling mid-sequence: the current REF completes, no burst continuation follows, and the block releases.

## Timing
- `own_ack` sampled high at edge N → PRE on `cmd_valid` in cycle N+1.
- REF command exactly max(t_rp,1) cycles after PRE. `grant` is coincident with REF.
- Next REF (burst), or the `own_rq` deassertion, comes exactly max(t_rfc,1) cycles after REF.
- `own_rq` stays low for at least 1 cycle between ownerships (four-phase handshake).
- Minimum single-refresh ownership with t_rp=1, t_rfc=1: own_rq high from ack edge through PRE, REF, and 1 wait cycle.

## Configuration
- `DDR_REFRESH_BURST_EN` defined: at WAIT_RFC expiry, if `en && want && (need || seq_idle) && burst_cnt<8`, go directly to REF. No new PRE is issued, since banks are still closed.
- `DDR_REFRESH_BURST_EN` undefined: always go to RELEASE after one REF. `burst_cnt` logic is omitted.

## Test plan
- Single refresh: t_rp=3, t_rfc=20, want=1, seq_idle=1, own_ack returned 2 cycles after own_rq → PRE 1 cycle after ack, REF+grant 3 cycles later, own_rq falls 20 cycles after REF, exactly one grant.
- Deferral: want=1, need=0, seq_idle=0 → own_rq stays 0 for 100 cycles. Raise need → own_rq rises the next cycle.
- Burst (macro defined): need=1, want held through 10 grants, t_rfc=5 → 1 PRE, then 8 REFs spaced 5 cycles apart, then release, then a new ownership with PRE.
- Burst disabled (macro undefined), same stimulus → one PRE+REF per ownership, own_rq low ≥1 cycle between ownerships.
- Zero timing: t_rp=0, t_rfc=0 → REF 1 cycle after PRE, release 1 cycle after REF.
- Reset mid-WAIT_RFC: assert rst_n=0 → own_rq, cmd_valid, grant, busy all 0 asynchronously. After release the block re-requests only on a fresh T.

Source files
------------

// File: rtl/ddr_refresh_sequencer.sv
// DDR3 refresh sequencer: borrows the command bus through a four-phase own_rq/own_ack
// handshake, then issues PRECHARGE ALL and REFRESH. Define DDR_REFRESH_BURST_EN for REF bursts (max 8).
module ddr_refresh_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] t_rp,
  input  logic [8:0] t_rfc,
  input  logic       want,
  input  logic       need,
  input  logic       seq_idle,
  output logic       own_rq,
  input  logic       own_ack,
  output logic       grant,
  output logic       cmd_valid,
  output logic       cmd_ras_n,
  output logic       cmd_cas_n,
  output logic       cmd_we_n,
  output logic       cmd_a10,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE, REQ, PRE, WAIT_RP, REF, WAIT_RFC, RELEASE
  } state_t;

  state_t     state, state_nxt;
  logic [8:0] wait_cnt, wait_cnt_nxt;
  logic       trig;
  logic       burst_go;

  // A programmed spacing of 0 behaves like 1; the count is the number of extra wait cycles.
  function automatic logic [8:0] spacing_load(input logic [8:0] t);
    return (t == 9'd0) ? 9'd0 : t - 9'd1;
  endfunction

  assign trig = en && (need || (want && seq_idle));

`ifdef DDR_REFRESH_BURST_EN
  logic [3:0] burst_cnt;

  // Banks stay closed across a burst, so continuation goes straight to REF without a new PRE.
  assign burst_go = en && want && (need || seq_idle) && (burst_cnt < 4'd8);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_cnt <= 4'd0;
    end else if (state_nxt == PRE) begin
      burst_cnt <= 4'd0;
    end else if (state_nxt == REF && burst_cnt != 4'hF) begin
      burst_cnt <= burst_cnt + 4'd1;
    end
  end
`else
  assign burst_go = 1'b0;
`endif

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      IDLE: begin
        if (trig && !own_ack) state_nxt = REQ;
      end
      REQ: begin
        if (own_ack) begin
          state_nxt    = PRE;
          wait_cnt_nxt = spacing_load({5'd0, t_rp});
        end
      end
      PRE, WAIT_RP: begin
        if (wait_cnt == 9'd0) begin
          state_nxt    = REF;
          wait_cnt_nxt = spacing_load(t_rfc);
        end else begin
          state_nxt    = WAIT_RP;
          wait_cnt_nxt = wait_cnt - 9'd1;
        end
      end
      REF, WAIT_RFC: begin
        if (wait_cnt == 9'd0) begin
          if (burst_go) begin
            state_nxt    = REF;
            wait_cnt_nxt = spacing_load(t_rfc);
          end else begin
            state_nxt = RELEASE;
          end
        end else begin
          state_nxt    = WAIT_RFC;
          wait_cnt_nxt = wait_cnt - 9'd1;
        end
      end
      RELEASE: begin
        if (!own_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wait_cnt  <= 9'd0;
      own_rq    <= 1'b0;
      grant     <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_ras_n <= 1'b1;
      cmd_cas_n <= 1'b1;
      cmd_we_n  <= 1'b1;
      cmd_a10   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_cnt_nxt;
      own_rq    <= (state_nxt inside {REQ, PRE, WAIT_RP, REF, WAIT_RFC});
      grant     <= (state_nxt == REF);
      cmd_valid <= (state_nxt == PRE) || (state_nxt == REF);
      cmd_ras_n <= !((state_nxt == PRE) || (state_nxt == REF));
      cmd_cas_n <= (state_nxt != REF);
      cmd_we_n  <= (state_nxt != PRE);
      cmd_a10   <= (state_nxt == PRE);
      busy      <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_ddr_refresh_sequencer.sv
// Bench for ddr_refresh_sequencer: timestamp-based ownership model compared every cycle,
// directed scenarios with literal timing expectations, then randomized traffic.
module tb_ddr_refresh_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0, want = 1'b0, need = 1'b0, seq_idle = 1'b0, own_ack = 1'b0;
  logic [3:0] t_rp = 4'd1;
  logic [8:0] t_rfc = 9'd1;
  logic       own_rq, grant, cmd_valid, cmd_ras_n, cmd_cas_n, cmd_we_n, cmd_a10, busy;
  logic [3:0] cmd_bus;

  localparam logic [3:0] C_NOP = 4'b1110;
  localparam logic [3:0] C_PRE = 4'b0101;
  localparam logic [3:0] C_REF = 4'b0010;

  int vectors = 0;
  int errors = 0;
  int cyc = 0;
  bit auto_ack = 1'b0;
  int ack_dly = 0;

  always #5 clk = ~clk;

  assign cmd_bus = {cmd_ras_n, cmd_cas_n, cmd_we_n, cmd_a10};

  ddr_refresh_sequencer dut (
    .clk(clk), .rst_n(rst_n), .en(en), .t_rp(t_rp), .t_rfc(t_rfc),
    .want(want), .need(need), .seq_idle(seq_idle), .own_rq(own_rq), .own_ack(own_ack),
    .grant(grant), .cmd_valid(cmd_valid), .cmd_ras_n(cmd_ras_n), .cmd_cas_n(cmd_cas_n),
    .cmd_we_n(cmd_we_n), .cmd_a10(cmd_a10), .busy(busy)
  );

  // Reference model: ownership flags plus the absolute edge index of the next scheduled command.
  bit   m_own, m_acked, m_rel, m_after;
  int   m_next, m_burst, m_now;
  logic e_rq, e_grant, e_valid, e_busy;
  logic [3:0] e_cmd;

  function automatic int at_least1(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  task automatic model_reset();
    m_own = 0; m_acked = 0; m_rel = 0; m_after = 0;
    m_next = 0; m_burst = 0; m_now = 0;
    e_rq = 0; e_grant = 0; e_valid = 0; e_busy = 0; e_cmd = C_NOP;
  endtask

  task automatic model_issue_ref();
    e_valid = 1; e_grant = 1; e_cmd = C_REF;
    m_burst++;
    m_next = m_now + at_least1(int'(t_rfc));
    m_after = 1;
  endtask

  function automatic bit burst_ok();
`ifdef DDR_REFRESH_BURST_EN
    return en && want && (need || seq_idle) && (m_burst < 8);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_step();
    bit trig;
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_now++;
    e_grant = 0; e_valid = 0; e_cmd = C_NOP;
    trig = en && (need || (want && seq_idle));
    if (m_rel) begin
      if (!own_ack) m_rel = 0;
    end else if (!m_own) begin
      if (trig && !own_ack) m_own = 1;
    end else if (!m_acked) begin
      if (own_ack) begin
        m_acked = 1; m_after = 0; m_burst = 0;
        e_valid = 1; e_cmd = C_PRE;
        m_next = m_now + at_least1(int'(t_rp));
      end
    end else if (m_now == m_next) begin
      if (!m_after || burst_ok()) model_issue_ref();
      else begin
        m_own = 0; m_acked = 0; m_rel = 1;
      end
    end
    e_rq = m_own;
    e_busy = m_own || m_rel;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic ack_drive();
    if (own_rq && !own_ack) begin
      if (ack_dly == 0) own_ack = 1'b1; else ack_dly--;
    end else if (!own_rq && own_ack) begin
      if (ack_dly == 0) own_ack = 1'b0; else ack_dly--;
    end else begin
      ack_dly = $urandom_range(0, 3);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
    chk("outputs_vs_model", {own_rq, grant, cmd_valid, busy, cmd_bus},
        {e_rq, e_grant, e_valid, e_busy, e_cmd});
    if (auto_ack) ack_drive();
  endtask

  task automatic drain();
    int n;
    n = 0;
    want = 0; need = 0; auto_ack = 1;
    while ((busy || own_ack) && n < 300) begin
      tick();
      n++;
    end
    chk("drain_to_idle", {busy, own_ack}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int rise, ackc, pre, refc, fall, grants, npre, nfall, ng, rqhi;
    int g[10];
    logic [3:0] pre_cmd, ref_cmd;
    logic prev_rq;

    model_reset();
    tick(); tick();
    chk("reset_outputs", {own_rq, grant, cmd_valid, busy, cmd_bus}, 8'h0E);
    rst_n = 1'b1;
    tick();

    // Single refresh with a manually returned ack two cycles after own_rq.
    t_rp = 4'd3; t_rfc = 9'd20; en = 1; want = 1; seq_idle = 1; need = 0; auto_ack = 0;
    rise = -1; ackc = -1; pre = -1; refc = -1; fall = -1; grants = 0;
    pre_cmd = 4'h0; ref_cmd = 4'h0;
    for (int i = 0; i < 200 && fall < 0; i++) begin
      tick();
      if (own_rq && rise < 0) rise = cyc;
      if (cmd_valid && cmd_bus == C_PRE) begin pre = cyc; pre_cmd = cmd_bus; end
      if (grant) begin grants++; refc = cyc; ref_cmd = cmd_bus; want = 0; end
      if (refc >= 0 && !own_rq && fall < 0) begin fall = cyc; own_ack = 0; end
      if (rise >= 0 && ackc < 0 && cyc == rise + 2) begin own_ack = 1; ackc = cyc; end
    end
    chk("single_pre_after_ack", pre - ackc, 1);
    chk("single_ref_after_pre", refc - pre, 3);
    chk("single_release_after_ref", fall - refc, 20);
    chk("single_grant_count", grants, 1);
    chk("pre_encoding", pre_cmd, 4'b0101);
    chk("ref_encoding", ref_cmd, 4'b0010);
    drain();

    // Deferral: pending but not urgent while the main sequencer is busy.
    en = 1; want = 1; need = 0; seq_idle = 0; auto_ack = 1; rqhi = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (own_rq) rqhi++;
    end
    chk("deferral_no_request", rqhi, 0);
    need = 1;
    tick();
    chk("need_raises_request", own_rq, 1);
    drain();

    // Zero timing: both spacings collapse to one cycle.
    t_rp = 4'd0; t_rfc = 9'd0; en = 1; want = 1; seq_idle = 1; need = 0; auto_ack = 1;
    pre = -1; refc = -1; fall = -1;
    for (int i = 0; i < 100 && fall < 0; i++) begin
      tick();
      if (cmd_valid && cmd_bus == C_PRE) pre = cyc;
      if (grant && refc < 0) begin refc = cyc; want = 0; end
      if (refc >= 0 && !own_rq && fall < 0) fall = cyc;
    end
    chk("zero_ref_after_pre", refc - pre, 1);
    chk("zero_release_after_ref", fall - refc, 1);
    drain();

    // Urgent stream held through ten grants.
    t_rp = 4'd2; t_rfc = 9'd5; en = 1; need = 1; want = 1; seq_idle = 0; auto_ack = 1;
    ng = 0; npre = 0; nfall = 0; prev_rq = own_rq;
    for (int i = 0; i < 10; i++) g[i] = 0;
    for (int i = 0; i < 600 && ng < 10; i++) begin
      tick();
      if (cmd_valid && cmd_bus == C_PRE) npre++;
      if (grant) begin g[ng] = cyc; ng++; end
      if (prev_rq && !own_rq) nfall++;
      prev_rq = own_rq;
    end
    chk("stream_grant_count", ng, 10);
`ifdef DDR_REFRESH_BURST_EN
    chk("burst_pre_count", npre, 2);
    chk("burst_span_8_refs", g[7] - g[0], 35);
    chk("burst_release_count", nfall, 1);
    chk("burst_second_owner_gap", (g[8] - g[7]) > 5, 1);
`else
    chk("nonburst_pre_count", npre, 10);
    chk("nonburst_release_count", nfall, 9);
    chk("nonburst_ref_gap", (g[1] - g[0]) > 5, 1);
`endif
    drain();

    // Reset asserted in the middle of the post-REF wait.
    t_rp = 4'd1; t_rfc = 9'd30; en = 1; want = 1; seq_idle = 1; need = 0; auto_ack = 1;
    grants = 0;
    for (int i = 0; i < 100 && grants == 0; i++) begin
      tick();
      if (grant) grants++;
    end
    chk("reset_test_got_grant", grants, 1);
    want = 0;
    tick(); tick(); tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_clears", {own_rq, cmd_valid, grant, busy}, 0);
    model_reset();
    own_ack = 0;
    tick(); tick(); tick();
    rst_n = 1'b1;
    rqhi = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (own_rq) rqhi++;
    end
    chk("no_request_without_fresh_trigger", rqhi, 0);
    want = 1;
    tick();
    chk("fresh_trigger_requests", own_rq, 1);
    drain();

    // Randomized traffic, including spacing changes mid-wait and en drops mid-sequence.
    auto_ack = 1; en = 1;
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 15) == 0) en = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 3) == 0) want = $urandom_range(0, 1);
      if ($urandom_range(0, 7) == 0) need = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 3) == 0) seq_idle = $urandom_range(0, 1);
      if ($urandom_range(0, 9) == 0) t_rp = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) t_rfc = 9'($urandom_range(0, 24));
      tick();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
